// File: rtl/reg_dump_pkg.sv
// Shared state type and sizing helpers for the register dump controller.
// Defining REG_DUMP_CHECKSUM_EN adds the CSUM state (trailing XOR byte).
package reg_dump_pkg;

  localparam int unsigned DefNbits = 32;
  localparam int unsigned NBYTES   = DefNbits / 8;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StSend,
    StNext,
`ifdef REG_DUMP_CHECKSUM_EN
    StCsum,
`endif
    StDone
  } state_e;

  function automatic int unsigned nbytes(input int unsigned nbits);
    return nbits / 8;
  endfunction

endpackage

// File: rtl/reg_dump_ser.sv
// Word-to-byte serializer: loads a word, presents its MSB byte and shifts left by
// one byte per accepted transfer.
module reg_dump_ser
  import reg_dump_pkg::*;
#(
  parameter int unsigned NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [NBITS-1:0] i_word,
  input  logic             i_shift,
  output logic [7:0]       o_byte,
  output logic             o_last
);

  localparam int unsigned NumBytes = nbytes(NBITS);
  localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;

  logic [NBITS-1:0] word_q, word_d;
  logic [IdxW-1:0]  idx_q, idx_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (i_load) begin
      word_d = i_word;
      idx_d  = '0;
    end else if (i_shift) begin
      word_d = word_q << 8;
      idx_d  = idx_q + 1'b1;
    end
  end

  assign o_byte = word_q[NBITS-1 -: 8];
  assign o_last = (idx_q == IdxW'(NumBytes - 1));

endmodule

// File: rtl/reg_dump_ctrl.sv
// Dumps registers 0..CELDAS-1 of a register file byte-by-byte over a valid/ready
// link. Optional trailing XOR checksum byte when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump_ctrl
  import reg_dump_pkg::*;
#(
  parameter int unsigned REGS   = 5,
  parameter int unsigned NBITS  = 32,
  parameter int unsigned CELDAS = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  output logic [REGS-1:0]  o_reg_addr,
  input  logic [NBITS-1:0] i_reg_dato,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [REGS-1:0] LastAddr = REGS'(CELDAS - 1);

  state_e          state_q, state_d;
  logic [REGS-1:0] addr_q, addr_d;
  logic            xfer;
  logic            ser_load, ser_shift, ser_last;
  logic [7:0]      ser_byte;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  reg_dump_ser #(
    .NBITS (NBITS)
  ) u_ser (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (ser_load),
    .i_word  (i_reg_dato),
    .i_shift (ser_shift),
    .o_byte  (ser_byte),
    .o_last  (ser_last)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign xfer = o_tx_valid & i_tx_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StLatch;
          addr_d  = '0;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StLatch: state_d = StSend;
      StSend: begin
`ifdef REG_DUMP_CHECKSUM_EN
        if (xfer) csum_d = csum_q ^ ser_byte;
`endif
        if (xfer && ser_last) state_d = StNext;
      end
      StNext: begin
        if (addr_q == LastAddr) begin
`ifdef REG_DUMP_CHECKSUM_EN
          state_d = StCsum;
`else
          state_d = StDone;
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StLatch;
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      StCsum: if (xfer) state_d = StDone;
`endif
      StDone: begin
        state_d = StIdle;
        addr_d  = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are Moore; the serializer only advances on an accepted byte.
  always_comb begin
    o_tx_valid = 1'b0;
    o_tx_data  = ser_byte;
    o_done     = 1'b0;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    unique case (state_q)
      StLatch: ser_load = 1'b1;
      StSend: begin
        o_tx_valid = 1'b1;
        ser_shift  = i_tx_ready;
      end
`ifdef REG_DUMP_CHECKSUM_EN
      StCsum: begin
        o_tx_valid = 1'b1;
        o_tx_data  = csum_q;
      end
`endif
      StDone:  o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_busy     = (state_q != StIdle);
  assign o_reg_addr = addr_q;

endmodule

// File: doc/reg_dump_ctrl.md
REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

Interface
REQ-001 Parameter REGS, 5: register-file address width.
REQ-002 Parameter NBITS, 32: register width; SHALL be a multiple of 8.
REQ-003 Parameter CELDAS, 32: number of registers dumped, 1..2**REGS.
REQ-004 Port i_clk, input, 1: the single clock; all state changes on rising edge.
REQ-005 Port i_reset, input, 1: asynchronous, active-high reset.
REQ-006 Port i_start, input, 1: dump request, sampled only in IDLE.
REQ-007 Port o_reg_addr, output, REGS: drives the register-file debug read address.
REQ-008 Port i_reg_dato, input, NBITS: combinational debug read data for o_reg_addr.
REQ-009 Port o_tx_data, output, 8: byte to the transmitter.
REQ-010 Port o_tx_valid, output, 1: o_tx_data valid.
REQ-011 Port i_tx_ready, input, 1: transmitter accepts the byte this cycle.
REQ-012 Port o_busy, output, 1: high in every state except IDLE.
REQ-013 Port o_done, output, 1: one-cycle pulse at dump completion.

Function
REQ-014 States SHALL be IDLE, LATCH, SEND, NEXT, CSUM, DONE.
REQ-015 IDLE: i_start=1 -> LATCH with o_reg_addr=0; i_start is ignored in all other states.
REQ-016 LATCH (1 cycle): capture i_reg_dato into a shift register, clear the byte index, -> SEND.
REQ-017 SEND: o_tx_valid=1, o_tx_data = latched word byte, MSB byte first.
REQ-018 A byte transfers on o_tx_valid & i_tx_ready; o_tx_valid and o_tx_data SHALL stay stable until then.
REQ-019 After byte NBITS/8-1 transfers -> NEXT; otherwise increment the byte index and stay in SEND.
REQ-020 NEXT (1 cycle): o_reg_addr < CELDAS-1 -> increment o_reg_addr, -> LATCH; o_reg_addr = CELDAS-1 -> CSUM if enabled, else DONE.
REQ-021 DONE: o_done=1 for exactly one cycle, -> IDLE; o_reg_addr returns to 0.
REQ-022 Each register SHALL be snapshotted in its LATCH cycle only; register-file writes after that cycle do not affect its bytes.
REQ-023 With i_tx_ready held high, each register SHALL take exactly 1 + NBITS/8 + 1 cycles.
REQ-024 i_tx_ready high outside SEND/CSUM SHALL have no effect.
REQ-025 o_tx_valid SHALL be 0 in IDLE, LATCH, NEXT, DONE.

Reset
REQ-026 On i_reset=1, immediately and regardless of state: state=IDLE, o_reg_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0, byte index=0, checksum=0.
REQ-027 Reset mid-dump SHALL abort it without an o_done pulse; the next i_start restarts from register 0.

Configuration
REQ-028 Macro REG_DUMP_CHECKSUM_EN defined: CSUM state is present; it sends one byte, the XOR of all dumped bytes, with SEND handshake rules, then -> DONE.
REQ-029 Macro REG_DUMP_CHECKSUM_EN undefined: no CSUM state and no checksum register; NEXT on the last register goes straight to DONE.

Structure
REQ-030 Package reg_dump_pkg SHALL hold the state enum and the constant NBYTES = NBITS/8.
REQ-031 One sub-module, reg_dump_ser (word-to-byte serializer with valid/ready), is natural; the FSM and address counter stay in reg_dump_ctrl.

Verification
REQ-032 Model register file reg[i]=i, ready held high, i_start pulsed -> bytes 00 00 00 00, 00 00 00 01 ... 00 00 00 1F; o_done 193 cycles after the i_start sample edge.
REQ-033 Same as REQ-032 with REG_DUMP_CHECKSUM_EN -> 129th byte is 0x00; o_done at cycle 194.
REQ-034 Model register file reg[2]=0xDEADBEEF; ready toggles 1-0-0-1 -> register 2 bytes DE AD BE EF; data stable while valid & !ready; no byte lost or duplicated.
REQ-035 i_start pulsed again during the dump; write reg[5]=0x12345678 after the LATCH of reg 5 -> a single dump only, and reg 5 still sends 00 00 00 05.
REQ-036 i_reset asserted mid-SEND of reg 7 -> o_tx_valid=0 and o_busy=0 immediately, no o_done; next i_start restarts at o_reg_addr=0.
